// File: rtl/analog_dir_encoder_pkg.sv
// Shared types for the analog stick to direction bus encoder.
// Axis state enum, direction bit positions in {up, down, left, right},
// and the helper that maps the two axis states onto the bus.
package analog_dir_encoder_pkg;

    typedef enum logic [1:0] {
        AX_CENTER = 2'd0,
        AX_NEG    = 2'd1,
        AX_POS    = 2'd2
    } axis_state_t;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    // An axis is only ever in one state, so opposite bits are mutually exclusive.
    function automatic logic [3:0] dir_from_axes(input axis_state_t x, input axis_state_t y);
        logic [3:0] d;
        d            = 4'b0000;
        d[DIR_UP]    = (y == AX_NEG);
        d[DIR_DOWN]  = (y == AX_POS);
        d[DIR_LEFT]  = (x == AX_NEG);
        d[DIR_RIGHT] = (x == AX_POS);
        return d;
    endfunction

endpackage

// File: rtl/analog_dir_encoder_if.sv
// Sample-in / direction-out bundle of the analog direction encoder.
// master: stick feed side (drives enable, samples); slave: the encoder.
// diroutput is {up, down, left, right}; dir_changed pulses on each change.
interface analog_dir_encoder_if;
    logic       enable;
    logic       sample_valid;
    logic [7:0] stick_x;
    logic [7:0] stick_y;
    logic [3:0] diroutput;
    logic       dir_changed;

    modport master (
        output enable, sample_valid, stick_x, stick_y,
        input  diroutput, dir_changed
    );

    modport slave (
        input  enable, sample_valid, stick_x, stick_y,
        output diroutput, dir_changed
    );
endinterface

// File: rtl/analog_dir_encoder_axis_hysteresis.sv
// Per-axis CENTER/NEG/POS classifier with press deadzone and release hysteresis.
// Ports: clock/reset, clear (force CENTER), eval (update strobe), value (signed 8b),
// state (registered axis state, changes only on eval edges or clear/reset).
module axis_hysteresis
    import analog_dir_encoder_pkg::*;
#(
    parameter logic [7:0] DEADZONE = 8'd48,
    parameter logic [7:0] HYST     = 8'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        eval,
    input  logic [7:0]  value,
    output axis_state_t state
);

    // 9-bit signed compares so -128 and -DEADZONE never wrap.
    localparam logic signed [8:0] PRESS  = $signed({1'b0, DEADZONE});
    localparam logic signed [8:0] REL    = $signed({1'b0, DEADZONE - HYST});
    localparam logic signed [8:0] NPRESS = -PRESS;
    localparam logic signed [8:0] NREL   = -REL;

    logic signed [8:0] v;
    assign v = $signed({value[7], value});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= AX_CENTER;
        end else if (clear) begin
            state <= AX_CENTER;
        end else if (eval) begin
            case (state)
                AX_CENTER: begin
                    if (v <= NPRESS)     state <= AX_NEG;
                    else if (v >= PRESS) state <= AX_POS;
                end
                AX_NEG: begin
                    if (v >= PRESS)      state <= AX_POS;     // full swing, skip center
                    else if (v > NREL)   state <= AX_CENTER;
                end
                AX_POS: begin
                    if (v <= NPRESS)     state <= AX_NEG;
                    else if (v < REL)    state <= AX_CENTER;
                end
                default: state <= AX_CENTER;
            endcase
        end
    end

endmodule

// File: rtl/analog_dir_encoder.sv
// Analog stick X/Y to {up, down, left, right} bus with deadzone, hysteresis, debounce.
// Ports: clock, reset (async active-high), bus (slave): enable, sample strobe and
// stick values in; registered diroutput and one-cycle dir_changed pulse out.
module analog_dir_encoder
    import analog_dir_encoder_pkg::*;
#(
    parameter logic [7:0]  DEADZONE      = 8'd48,
    parameter logic [7:0]  HYST          = 8'd16,
    parameter logic [15:0] STABLE_CYCLES = 16'd4,
    parameter int          CNT_W         = 16
) (
    input logic                  clock,
    input logic                  reset,
    analog_dir_encoder_if.slave  bus
);

    localparam int S_EFF = (STABLE_CYCLES == 16'd0) ? 1 : int'(STABLE_CYCLES);
    // The first edge a new candidate is visible is the "changed" edge and counts
    // as one of the S_EFF cycles, so the steady-edge counter commits at S_EFF-2.
    localparam logic [CNT_W-1:0] CNT_TGT = (S_EFF >= 2) ? CNT_W'(S_EFF - 2) : '0;
    localparam bit               BYPASS  = (S_EFF == 1);

    logic [7:0]  sample_x;
    logic [7:0]  sample_y;
    logic        eval;
    logic        clear;
    axis_state_t x_state;
    axis_state_t y_state;
    logic [3:0]  candidate;
    logic [3:0]  last_candidate;
    logic [CNT_W-1:0] cnt;

    assign clear = ~bus.enable;

    // Samples are ignored while disabled; eval marks the edge after a capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_x <= '0;
            sample_y <= '0;
            eval     <= 1'b0;
        end else begin
            eval <= bus.sample_valid & bus.enable;
            if (bus.sample_valid && bus.enable) begin
                sample_x <= bus.stick_x;
                sample_y <= bus.stick_y;
            end
        end
    end

    axis_hysteresis #(.DEADZONE(DEADZONE), .HYST(HYST)) u_ax_x (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .eval  (eval),
        .value (sample_x),
        .state (x_state)
    );

    axis_hysteresis #(.DEADZONE(DEADZONE), .HYST(HYST)) u_ax_y (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .eval  (eval),
        .value (sample_y),
        .state (y_state)
    );

    assign candidate = dir_from_axes(x_state, y_state);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.diroutput   <= 4'b0000;
            bus.dir_changed <= 1'b0;
            last_candidate  <= 4'b0000;
            cnt             <= '0;
        end else begin
            last_candidate  <= candidate;
            bus.dir_changed <= 1'b0;
            if (!bus.enable) begin
                cnt             <= '0;
                bus.diroutput   <= 4'b0000;
                bus.dir_changed <= |bus.diroutput;
            end else if (candidate == bus.diroutput) begin
                cnt <= '0;
            end else if (BYPASS) begin
                bus.diroutput   <= candidate;
                bus.dir_changed <= 1'b1;
                cnt             <= '0;
            end else if (candidate == last_candidate) begin
                if (cnt == CNT_TGT) begin
                    bus.diroutput   <= candidate;
                    bus.dir_changed <= 1'b1;
                    cnt             <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                // Candidate moved: restart the stability window.
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_analog_dir_encoder.sv
module tb_analog_dir_encoder;
    import analog_dir_encoder_pkg::*;

    localparam int STABLE = 4;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    analog_dir_encoder_if bus();

    analog_dir_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One edge with sample_valid high; returns just after that edge (edge k).
    task automatic sample(input logic [7:0] x, input logic [7:0] y);
        bus.stick_x      = x;
        bus.stick_y      = y;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    // Hold n edges expecting diroutput==val and no dir_changed pulse.
    task automatic expect_stay(input string tag, input logic [3:0] val, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.diroutput !== val || bus.dir_changed !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Called right after the sample edge k: old value through k+STABLE,
    // new value with a pulse at k+1+STABLE, pulse gone one edge later.
    task automatic expect_latency(input string tag, input logic [3:0] oldv, input logic [3:0] newv);
        expect_stay({tag, "_hold"}, oldv, STABLE);
        tick();
        check({tag, "_dir"}, bus.diroutput, newv);
        check({tag, "_pulse"}, bus.dir_changed, 1'b1);
        tick();
        check({tag, "_pulse_end"}, bus.dir_changed, 1'b0);
        check({tag, "_dir_keep"}, bus.diroutput, newv);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.enable       = 1'b1;
        bus.sample_valid = 1'b0;
        bus.stick_x      = 8'd0;
        bus.stick_y      = 8'd0;
        #1;
        check("rst_dir", bus.diroutput, 4'b0000);
        check("rst_pulse", bus.dir_changed, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Reset mid-count: commit right first, then start a down+right count.
        sample(8'd100, 8'd0);
        expect_latency("pre_rst", 4'b0000, 4'b0001);
        sample(8'd100, 8'd100);
        for (int i = 0; i < 4; i++) tick();
        #3 reset = 1'b1;
        #1;
        check("midrst_dir", bus.diroutput, 4'b0000);
        check("midrst_pulse", bus.dir_changed, 1'b0);
        tick();
        reset = 1'b0;
        check("midrst_x_state", 32'(dut.u_ax_x.state), 32'(AX_CENTER));
        check("midrst_y_state", 32'(dut.u_ax_y.state), 32'(AX_CENTER));
        expect_stay("post_rst_quiet", 4'b0000, 10);

        // Deadzone edge.
        sample(8'd47, 8'd0);
        expect_stay("x47_quiet", 4'b0000, 8);
        sample(8'd48, 8'd0);
        expect_latency("x48", 4'b0000, 4'b0001);

        // Hysteresis from POS, then no press from CENTER inside deadzone.
        sample(8'd32, 8'd0);
        expect_stay("x32_hold", 4'b0001, 8);
        sample(8'd31, 8'd0);
        expect_latency("x31_rel", 4'b0001, 4'b0000);
        sample(8'd40, 8'd0);
        expect_stay("x40_quiet", 4'b0000, 8);

        // Corners and full swings.
        sample(8'h80, 8'h80);
        expect_latency("neg_corner", 4'b0000, 4'b1010);
        sample(8'd127, 8'd127);
        expect_latency("pos_corner", 4'b1010, 4'b0101);
        sample(8'h80, 8'd0);
        expect_latency("left", 4'b0101, 4'b0010);
        sample(8'd127, 8'd0);
        expect_latency("swing_lr", 4'b0010, 4'b0001);
        sample(8'd0, 8'd0);
        expect_latency("to_center", 4'b0001, 4'b0000);

        // Glitch shorter than the stability window.
        sample(8'd100, 8'd0);
        tick();
        tick();
        sample(8'd0, 8'd0);
        expect_stay("glitch_quiet", 4'b0000, 10);
        sample(8'd100, 8'd0);
        expect_latency("held", 4'b0000, 4'b0001);

        // Enable drop; samples offered while disabled must be ignored.
        bus.enable       = 1'b0;
        bus.stick_x      = 8'h9C;
        bus.sample_valid = 1'b1;
        tick();
        check("dis_dir", bus.diroutput, 4'b0000);
        check("dis_pulse", bus.dir_changed, 1'b1);
        tick();
        check("dis_pulse_end", bus.dir_changed, 1'b0);
        tick();
        bus.sample_valid = 1'b0;
        bus.enable       = 1'b1;
        expect_stay("reen_quiet", 4'b0000, 8);
        sample(8'd100, 8'd0);
        expect_latency("reen", 4'b0000, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
